// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-cathode 7-segment display.
// Drives one BCD code plus an active-low digit enable per slot, with blanking and a guard interval.
module seg_scan_ctrl #(
  parameter int unsigned NDIG  = 4,
  parameter int unsigned DIV   = 50000,
  parameter int unsigned GUARD = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [2:0]      wr_addr,
  input  logic [3:0]      wr_data,
  input  logic            blank_lz,
  output logic [3:0]      bcd_out,
  output logic [NDIG-1:0] dig_sel,
  output logic            frame_start
);

  localparam int unsigned CntW = $clog2(DIV);
  localparam int unsigned IdxW = $clog2(NDIG);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [3:0]      dreg_q [NDIG];
  logic [3:0]      dreg_d [NDIG];

  logic            slot_end;
  logic            in_guard;
  logic [NDIG-1:0] blanked;
  logic [3:0]      cur_val;
  logic            cur_blank;

  logic [3:0]      bcd_d;
  logic [NDIG-1:0] sel_d;
  logic            fs_d;

  // Slot prescaler and digit index.
  always_comb begin
    slot_end = (cnt_q == CntW'(DIV - 1));
    cnt_d    = slot_end ? '0 : cnt_q + CntW'(1);
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IdxW'(NDIG - 1)) ? '0 : idx_q + IdxW'(1);
    end
  end

  // Out-of-range addresses match no register and are dropped.
  always_comb begin
    dreg_d = dreg_q;
    for (int i = 0; i < NDIG; i++) begin
      if (wr_en && (wr_addr == 3'(i))) begin
        dreg_d[i] = wr_data;
      end
    end
  end

  // A digit is leading-zero blanked when it and every more significant digit are zero.
  always_comb begin
    blanked = '0;
    for (int i = 0; i < NDIG; i++) begin
      logic all_zero;
      all_zero = 1'b1;
      for (int j = i; j < NDIG; j++) begin
        if (dreg_q[j] != 4'd0) begin
          all_zero = 1'b0;
        end
      end
      blanked[i] = (dreg_q[i] > 4'd9) || (blank_lz && (i != 0) && all_zero);
    end
  end

  always_comb begin
    cur_val   = '0;
    cur_blank = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_val   = dreg_q[i];
        cur_blank = blanked[i];
      end
    end
  end

  always_comb begin
    in_guard = (32'(cnt_q) < GUARD);
    bcd_d    = cur_blank ? 4'd0 : cur_val;
    sel_d    = '1;
    if (!in_guard && !cur_blank) begin
      for (int i = 0; i < NDIG; i++) begin
        if (idx_q == IdxW'(i)) begin
          sel_d[i] = 1'b0;
        end
      end
    end
    fs_d = (idx_q == '0) && (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      for (int i = 0; i < NDIG; i++) begin
        dreg_q[i] <= '0;
      end
      bcd_out     <= '0;
      dig_sel     <= '1;
      frame_start <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      dreg_q      <= dreg_d;
      bcd_out     <= bcd_d;
      dig_sel     <= sel_d;
      frame_start <= fs_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NDIG=4, DIV=4, GUARD=1.
module tb_seg_scan_ctrl;

  localparam int unsigned NDIG  = 4;
  localparam int unsigned DIV   = 4;
  localparam int unsigned GUARD = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_en;
  logic [2:0]      wr_addr;
  logic [3:0]      wr_data;
  logic            blank_lz;
  logic [3:0]      bcd_out;
  logic [NDIG-1:0] dig_sel;
  logic            frame_start;

  int n_checks = 0;
  int n_fail   = 0;
  // Edges since the last reset release; outputs after edge t reflect scan position t-1.
  int t        = 0;

  seg_scan_ctrl #(
    .NDIG (NDIG),
    .DIV  (DIV),
    .GUARD(GUARD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .blank_lz   (blank_lz),
    .bcd_out    (bcd_out),
    .dig_sel    (dig_sel),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic chk(input string tag, input logic [3:0] exp_sel, input logic [3:0] exp_bcd,
                     input logic exp_fs);
    n_checks++;
    assert (dig_sel === exp_sel) else begin
      n_fail++;
      $error("FAIL %s dig_sel observed %b expected %b", tag, dig_sel, exp_sel);
    end
    n_checks++;
    assert (bcd_out === exp_bcd) else begin
      n_fail++;
      $error("FAIL %s bcd_out observed %0d expected %0d", tag, bcd_out, exp_bcd);
    end
    n_checks++;
    assert (frame_start === exp_fs) else begin
      n_fail++;
      $error("FAIL %s frame_start observed %b expected %b", tag, frame_start, exp_fs);
    end
  endtask

  task automatic wr(input logic [2:0] addr, input logic [3:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    step();
    wr_en   = 1'b0;
  endtask

  // Advance until the next edge will present the first (guard) clock of digit d's slot.
  task automatic wait_slot(input int d);
    for (int k = 0; k < 16 && (t % 16) != 4 * d; k++) begin
      step();
    end
  endtask

  task automatic check_slot(input string tag, input int d, input logic [3:0] exp_lit,
                            input logic [3:0] exp_bcd);
    wait_slot(d);
    step();
    chk({tag, "_guard"}, 4'b1111, exp_bcd, d == 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk({tag, "_lit"}, exp_lit, exp_bcd, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    blank_lz = 1'b0;

    // Reset and frame timing
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold", 4'b1111, 4'd0, 1'b0);
    rst = 1'b0;
    t   = 0;
    step();
    chk("rst_first", 4'b1111, 4'd0, 1'b1);
    step();
    chk("rst_d0_lit", 4'b1110, 4'd0, 1'b0);
    repeat (14) step();
    chk("rst_d3_end", 4'b0111, 4'd0, 1'b0);
    step();
    chk("rst_frame2", 4'b1111, 4'd0, 1'b1);

    // Basic scan
    wr(3'd0, 4'd1);
    wr(3'd1, 4'd2);
    wr(3'd2, 4'd3);
    wr(3'd3, 4'd4);
    check_slot("scan_d0", 0, 4'b1110, 4'd1);
    check_slot("scan_d1", 1, 4'b1101, 4'd2);
    check_slot("scan_d2", 2, 4'b1011, 4'd3);
    check_slot("scan_d3", 3, 4'b0111, 4'd4);

    // Leading-zero blanking: digits 3..0 = 0,0,5,0
    wr(3'd3, 4'd0);
    wr(3'd2, 4'd0);
    wr(3'd1, 4'd5);
    wr(3'd0, 4'd0);
    blank_lz = 1'b1;
    check_slot("lz_d3", 3, 4'b1111, 4'd0);
    check_slot("lz_d2", 2, 4'b1111, 4'd0);
    check_slot("lz_d1", 1, 4'b1101, 4'd5);
    check_slot("lz_d0", 0, 4'b1110, 4'd0);
    blank_lz = 1'b0;
    check_slot("nolz_d3", 3, 4'b0111, 4'd0);
    check_slot("nolz_d2", 2, 4'b1011, 4'd0);
    wr(3'd1, 4'd0);
    blank_lz = 1'b1;
    check_slot("zero_d1", 1, 4'b1111, 4'd0);
    check_slot("zero_d3", 3, 4'b1111, 4'd0);
    check_slot("zero_d0", 0, 4'b1110, 4'd0);

    // Invalid code and out-of-range address
    blank_lz = 1'b0;
    wr(3'd0, 4'd1);
    wr(3'd1, 4'd2);
    wr(3'd2, 4'd3);
    wr(3'd3, 4'd4);
    wr(3'd2, 4'hA);
    check_slot("inv_d2", 2, 4'b1111, 4'd0);
    check_slot("inv_d3", 3, 4'b0111, 4'd4);
    check_slot("inv_d1", 1, 4'b1101, 4'd2);
    wr(3'd5, 4'd9);
    check_slot("oob_d0", 0, 4'b1110, 4'd1);
    check_slot("oob_d1", 1, 4'b1101, 4'd2);
    check_slot("oob_d2", 2, 4'b1111, 4'd0);
    check_slot("oob_d3", 3, 4'b0111, 4'd4);

    // Mid-slot write to digit 1
    wr(3'd2, 4'd3);
    wait_slot(1);
    step();
    chk("mid_guard", 4'b1111, 4'd2, 1'b0);
    wr_en   = 1'b1;
    wr_addr = 3'd1;
    wr_data = 4'd7;
    step();
    wr_en   = 1'b0;
    chk("mid_lit1", 4'b1101, 4'd2, 1'b0);
    step();
    chk("mid_lit2", 4'b1101, 4'd7, 1'b0);
    step();
    chk("mid_lit3", 4'b1101, 4'd7, 1'b0);
    step();
    chk("mid_next", 4'b1111, 4'd3, 1'b0);

    // Reset during digit 2's slot
    wait_slot(2);
    step();
    chk("rmid_guard", 4'b1111, 4'd3, 1'b0);
    step();
    chk("rmid_lit", 4'b1011, 4'd3, 1'b0);
    rst = 1'b1;
    step();
    chk("rmid_reset", 4'b1111, 4'd0, 1'b0);
    rst = 1'b0;
    t   = 0;
    step();
    chk("rmid_restart", 4'b1111, 4'd0, 1'b1);
    check_slot("rmid_d1", 1, 4'b1101, 4'd0);
    check_slot("rmid_d3", 3, 4'b0111, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
